// File: rtl/checkpoint_ctrl.sv
// rtl/checkpoint_ctrl.sv - rename checkpoint slot allocator with in-order retire and mispredict restore
module checkpoint_ctrl #(
    parameter int NUM_CKPT = 8,
    parameter int TAG_W    = 5,
    parameter int IDX_W    = $clog2(NUM_CKPT)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             alloc_req_i,
    input  logic [TAG_W-1:0] alloc_tag_i,
    output logic             alloc_gnt_o,
    output logic             ckpt_we_o,
    output logic [IDX_W-1:0] ckpt_idx_o,
    input  logic             resolve_valid_i,
    input  logic [TAG_W-1:0] resolve_tag_i,
    input  logic             resolve_mispred_i,
    output logic             restore_en_o,
    output logic [IDX_W-1:0] restore_idx_o,
    output logic             resolve_miss_o,
    output logic             full_o,
    output logic [IDX_W:0]   count_o
);

    typedef enum logic {S_IDLE, S_RESTORE} state_e;

    state_e              state_q, state_d;
    logic [NUM_CKPT-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q [NUM_CKPT];
    logic [IDX_W-1:0]    head_q, head_d;
    logic [IDX_W-1:0]    tail_q, tail_d;
    logic [IDX_W-1:0]    rest_idx_q, rest_idx_d;
    logic [IDX_W:0]      count_q, count_d;
    logic                miss_q, miss_d;

    logic                idle, full, any_match, hit, mispred, grant, retire;
    logic [IDX_W-1:0]    match_idx, mdist;

    always_comb begin
        any_match = 1'b0;
        match_idx = '0;
        for (int i = 0; i < NUM_CKPT; i++) begin
            if (valid_q[i] && tag_q[i] == resolve_tag_i) begin
                any_match = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    assign idle    = (state_q == S_IDLE);
    assign full    = (count_q == (IDX_W+1)'(NUM_CKPT));
    assign hit     = idle & resolve_valid_i & ~resolve_mispred_i & any_match;
    assign mispred = idle & resolve_valid_i & resolve_mispred_i & any_match;
    assign grant   = alloc_req_i & ~full & idle & ~(resolve_valid_i & resolve_mispred_i);
    assign retire  = (count_q != '0) & ~valid_q[head_q] & ~mispred;
    assign mdist   = match_idx - head_q;

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q + (IDX_W+1)'(grant) - (IDX_W+1)'(retire);
        rest_idx_d = rest_idx_q;
        miss_d     = idle & resolve_valid_i & ~any_match;

        case (state_q)
            S_IDLE:    if (mispred) state_d = S_RESTORE;
            S_RESTORE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        if (retire) head_d = head_q + 1'b1;
        if (hit) valid_d[match_idx] = 1'b0;
        if (grant) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
        // Slots at or beyond the mispredicted one in program order (distance from head) die;
        // anything past the live window is already invalid, so no upper bound is needed.
        if (mispred) begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                if (IDX_W'(IDX_W'(i) - head_q) >= mdist) valid_d[i] = 1'b0;
            end
            tail_d     = match_idx;
            count_d    = {1'b0, mdist};
            rest_idx_d = match_idx;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rest_idx_q <= '0;
            miss_q     <= 1'b0;
            for (int i = 0; i < NUM_CKPT; i++) tag_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rest_idx_q <= rest_idx_d;
            miss_q     <= miss_d;
            if (grant) tag_q[tail_q] <= alloc_tag_i;
        end
    end

    assign alloc_gnt_o    = grant;
    assign ckpt_we_o      = grant;
    assign ckpt_idx_o     = tail_q;
    assign restore_en_o   = (state_q == S_RESTORE);
    assign restore_idx_o  = rest_idx_q;
    assign resolve_miss_o = miss_q;
    assign full_o         = full;
    assign count_o        = count_q;

endmodule

// File: tb/tb_checkpoint_ctrl.sv
// tb/tb_checkpoint_ctrl.sv - scoreboard bench for checkpoint_ctrl with directed vectors
module tb_checkpoint_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       alloc_req = 1'b0;
    logic [4:0] alloc_tag = '0;
    logic       alloc_gnt, ckpt_we;
    logic [2:0] ckpt_idx;
    logic       resolve_valid = 1'b0;
    logic [4:0] resolve_tag = '0;
    logic       resolve_mispred = 1'b0;
    logic       restore_en;
    logic [2:0] restore_idx;
    logic       resolve_miss, full;
    logic [3:0] count;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        string name;
        int    gnt;
        int    idx;
        int    ren;
        int    ridx;
        int    miss;
        int    cnt;
    } exp_t;

    exp_t exp_q[$];

    checkpoint_ctrl #(.NUM_CKPT(8), .TAG_W(5), .IDX_W(3)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .alloc_req_i       (alloc_req),
        .alloc_tag_i       (alloc_tag),
        .alloc_gnt_o       (alloc_gnt),
        .ckpt_we_o         (ckpt_we),
        .ckpt_idx_o        (ckpt_idx),
        .resolve_valid_i   (resolve_valid),
        .resolve_tag_i     (resolve_tag),
        .resolve_mispred_i (resolve_mispred),
        .restore_en_o      (restore_en),
        .restore_idx_o     (restore_idx),
        .resolve_miss_o    (resolve_miss),
        .full_o            (full),
        .count_o           (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string field, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s %s: got %0d expected %0d", nm, field, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "alloc_gnt", int'(alloc_gnt), e.gnt);
            chk(e.name, "ckpt_we", int'(ckpt_we), e.gnt);
            if (e.gnt != 0) chk(e.name, "ckpt_idx", int'(ckpt_idx), e.idx);
            chk(e.name, "restore_en", int'(restore_en), e.ren);
            if (e.ren != 0) chk(e.name, "restore_idx", int'(restore_idx), e.ridx);
            chk(e.name, "resolve_miss", int'(resolve_miss), e.miss);
            chk(e.name, "count", int'(count), e.cnt);
            chk(e.name, "full", int'(full), (e.cnt == 8) ? 1 : 0);
        end
    end

    // One cycle: drive inputs, queue what the outputs must show this cycle, advance.
    task automatic step(input string nm, input int req, input int tag, input int rv, input int rt,
                        input int rm, input int eg, input int eidx, input int er, input int eridx,
                        input int em, input int ec);
        exp_t e;
        alloc_req       = req[0];
        alloc_tag       = tag[4:0];
        resolve_valid   = rv[0];
        resolve_tag     = rt[4:0];
        resolve_mispred = rm[0];
        e.name = nm; e.gnt = eg; e.idx = eidx; e.ren = er; e.ridx = eridx; e.miss = em; e.cnt = ec;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        exp_t e;
        rst = 1'b1;
        alloc_req = 1'b0; resolve_valid = 1'b0; resolve_mispred = 1'b0;
        e.name = nm; e.gnt = 0; e.idx = 0; e.ren = 0; e.ridx = 0; e.miss = 0; e.cnt = 0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset("reset");

        for (int k = 0; k < 8; k++) step("fill", 1, k, 0, 0, 0, 1, k, 0, 0, 0, k);
        step("ninth_req", 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 8);
        step("full_hit0", 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 8);
        step("full_retire", 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 8);
        step("full_regrant", 1, 8, 0, 0, 0, 1, 0, 0, 0, 0, 7);
        step("full_again", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8);

        do_reset("reset2");
        for (int k = 0; k < 4; k++) step("alloc4", 1, k, 0, 0, 0, 1, k, 0, 0, 0, k);
        step("hit2", 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 4);
        step("hit0", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4);
        step("drain0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
        step("stop_at1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        step("hit1", 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 3);
        step("drain1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        step("drain2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        step("stop_at3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("hold_at3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        do_reset("reset3");
        for (int k = 0; k < 6; k++) step("alloc6", 1, k, 0, 0, 0, 1, k, 0, 0, 0, k);
        step("mispred3", 1, 9, 1, 3, 1, 0, 0, 0, 0, 0, 6);
        step("restore", 1, 10, 1, 4, 0, 0, 0, 1, 3, 0, 3);
        step("post_restore", 1, 11, 0, 0, 0, 1, 3, 0, 0, 0, 3);
        step("idle4", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
        step("hit_killed4", 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 4);
        step("miss_pulse", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
        step("miss_gone", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);

        do_reset("reset4");
        for (int k = 0; k < 3; k++) step("alloc3", 1, k, 0, 0, 0, 1, k, 0, 0, 0, k);
        step("hit_head0", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3);
        step("retire0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        step("settle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        step("mispred_head", 1, 7, 1, 1, 1, 0, 0, 0, 0, 0, 2);
        step("restore_head", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        step("empty", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("realloc", 1, 3, 0, 0, 0, 1, 1, 0, 0, 0, 0);

        do_reset("reset5");
        step("alloc_a", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step("alloc_b", 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1);
        step("hit9", 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 2);
        step("miss9", 0, 0, 1, 9, 1, 0, 0, 0, 0, 1, 2);
        step("miss9_mp", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        step("unchanged", 1, 2, 0, 0, 0, 1, 2, 0, 0, 0, 2);
        step("mispred1", 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 3);
        do_reset("reset_in_restore");
        step("after_reset", 1, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
